// File: rtl/rx_frame.sv
// rx_frame: receiving end of the one-bit-per-clock serial link.
//
// Line format, one bit per clock and no oversampling:
//   start (0), DATA_W data bits LSB first, INSTR_W instruction bits LSB first, stop (1).
// The transmitter and this receiver run on the same clock.
//
// Ports:
//   clock        system clock, all state on its rising edge
//   reset_n      asynchronous active-low reset
//   rx_in        serial line, idles high
//   dado         last good data field
//   instrucao    last good instruction field
//   data_valid   one-cycle strobe: dado/instrucao were just updated
//   frame_error  one-cycle strobe: stop bit was sampled as 0
//   busy         high while a frame is in progress (DATA and STOP states)
//   bit_count    debug: index of the next payload bit, 0..DATA_W+INSTR_W
//   frame_count  debug: number of good frames, wraps silently

module rx_frame #(
    parameter int unsigned DATA_W  = 4,
    parameter int unsigned INSTR_W = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               rx_in,
    output logic [DATA_W-1:0]  dado,
    output logic [INSTR_W-1:0] instrucao,
    output logic               data_valid,
    output logic               frame_error,
    output logic               busy,
    output logic [3:0]         bit_count,
    output logic [CNT_W-1:0]   frame_count
);

    localparam int unsigned PAY_W    = DATA_W + INSTR_W;
    // bit_count is a fixed 4-bit debug port, so the payload must fit in 15 bits.
    localparam logic [3:0]  LAST_BIT = 4'(PAY_W - 1);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StData     = 2'd1,
        StStop     = 2'd2,
        StWaitHigh = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               rx_q;
    logic [PAY_W-1:0]   shift_q, shift_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]  dado_q, dado_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    logic               ferr_q, ferr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // State register and the single input flop; the FSM only ever looks at rx_q.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_q      <= 1'b1;
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            dado_q    <= '0;
            instr_q   <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            rx_q      <= rx_in;
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            dado_q    <= dado_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        dado_d    = dado_q;
        instr_d   = instr_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        cnt_d     = cnt_q;

        case (state_q)
            StIdle: begin
                if (!rx_q) begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                end
            end

            StData: begin
                // Drop the sampled bit at its payload position; the loop keeps
                // the select index within the register width.
                for (int unsigned i = 0; i < PAY_W; i++) begin
                    if (bit_cnt_q == 4'(i)) begin
                        shift_d[i] = rx_q;
                    end
                end
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == LAST_BIT) begin
                    state_d = StStop;
                end
            end

            StStop: begin
                bit_cnt_d = '0;
                if (rx_q) begin
                    dado_d  = shift_q[DATA_W-1:0];
                    instr_d = shift_q[PAY_W-1:DATA_W];
                    valid_d = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    // Straight to IDLE so a start bit right after the stop bit is caught.
                    state_d = StIdle;
                end else begin
                    ferr_d  = 1'b1;
                    state_d = StWaitHigh;
                end
            end

            StWaitHigh: begin
                // A line stuck low after a bad stop bit must not look like new starts.
                if (rx_q) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d   = StIdle;
                bit_cnt_d = '0;
            end
        endcase
    end

    assign dado        = dado_q;
    assign instrucao   = instr_q;
    assign data_valid  = valid_q;
    assign frame_error = ferr_q;
    assign busy        = (state_q == StData) || (state_q == StStop);
    assign bit_count   = bit_cnt_q;
    assign frame_count = cnt_q;

endmodule
